// File: rtl/lifo_pkg.sv
// Shared definitions for the LIFO stack: accepted-operation encoding and the
// occupancy-counter width helper.
// Optional build macro used by lifo_stack: LIFO_WATERMARK_EN.
package lifo_pkg;

    // Operation actually performed on a given edge. Rejected requests
    // decode to OP_IDLE or OP_PUSH; the error flags are derived separately.
    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_PUSH = 2'b01,
        OP_POP  = 2'b10,
        OP_SWAP = 2'b11
    } lifo_op_e;

    // Number of bits needed to hold an occupancy from 0 up to depth inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage : lifo_pkg

// File: rtl/lifo_mem.sv
// Storage array for the LIFO stack: DEPTH x DATA_W registers, one synchronous
// write port and one asynchronous read port. Addresses are occupancy-width
// values; a read address outside 0..DEPTH-1 returns zero.
module lifo_mem
    import lifo_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = cnt_width(DEPTH)
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    // Write the addressed entry on an enabled edge.
    // NOTE: the array has no reset on purpose; contents are only ever read
    // below the occupancy count, so a reset would cost a clear path per entry
    // for no functional gain.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (i_we && (i_waddr == ADDR_W'(i))) begin
                r_mem[i] <= i_wdata;
            end
        end
    end

    // Compare-based read mux, so the full-width occupancy address needs no
    // truncation and an out-of-range address simply yields zero.
    // NOTE: the output gets a default before the loop so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        o_rdata = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (i_raddr == ADDR_W'(i)) begin
                o_rdata = r_mem[i];
            end
        end
    end

endmodule : lifo_mem

// File: rtl/lifo_stack.sv
// Parametrised synchronous LIFO stack with registered pop data and valid
// strobe, same-cycle replace-top (push+pop), combinational top-entry peek,
// occupancy count and sticky overflow/underflow flags.
// Optional build macro: LIFO_WATERMARK_EN adds almost_full / almost_empty.
module lifo_stack
    import lifo_pkg::*;
#(
    parameter  int DATA_W    = 8,
    parameter  int DEPTH     = 8,
    parameter  int AFULL_LVL = DEPTH - 2,
    localparam int CNT_W     = cnt_width(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    input  logic              clr_err,
    output logic [DATA_W-1:0] pop_data,
    output logic              pop_valid,
    output logic [DATA_W-1:0] top_data,
    output logic              empty,
    output logic              full,
    output logic [CNT_W-1:0]  count,
    output logic              overflow,
    output logic              underflow
`ifdef LIFO_WATERMARK_EN
    ,
    output logic              almost_full,
    output logic              almost_empty
`endif
);

    // Elaboration-time parameter sanity checks.
    if (DEPTH < 2) begin : g_bad_depth
        $error("lifo_stack: DEPTH must be at least 2");
    end
    if ((AFULL_LVL < 0) || (AFULL_LVL > DEPTH)) begin : g_bad_afull
        $error("lifo_stack: AFULL_LVL must lie in 0..DEPTH");
    end

    logic [CNT_W-1:0]  r_count;
    logic [DATA_W-1:0] r_pop_data;
    logic              r_pop_valid;
    logic              r_overflow;
    logic              r_underflow;

    logic              w_empty;
    logic              w_full;
    logic [CNT_W-1:0]  w_top_idx;
    logic [CNT_W-1:0]  w_waddr;
    logic              w_we;
    logic [DATA_W-1:0] w_top_data;
    logic              w_pop_acc;
    logic              w_push_drop;
    logic              w_pop_reject;
    lifo_op_e          w_op;

    // Status is derived from the occupancy register alone.
    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == CNT_W'(DEPTH));
    assign w_top_idx = r_count - CNT_W'(1);

    // Decode the request pair into the operation that is actually accepted.
    // Push+pop on an empty stack degrades to a plain push.
    always_comb begin
        w_op = OP_IDLE;
        if (push && pop && !w_empty) begin
            w_op = OP_SWAP;
        end else if (push && !w_full) begin
            w_op = OP_PUSH;
        end else if (pop && !push && !w_empty) begin
            w_op = OP_POP;
        end
    end

    // Error conditions: a lone push while full, or any pop while empty.
    assign w_push_drop  = push && !pop && w_full;
    assign w_pop_reject = pop && w_empty;
    assign w_pop_acc    = (w_op == OP_POP) || (w_op == OP_SWAP);

    // A swap overwrites the current top; a push writes one slot above it.
    assign w_we    = (w_op == OP_PUSH) || (w_op == OP_SWAP);
    assign w_waddr = (w_op == OP_SWAP) ? w_top_idx : r_count;

    lifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (CNT_W)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (push_data),
        .i_raddr (w_top_idx),
        .o_rdata (w_top_data)
    );

    // Occupancy, pop data/strobe and sticky error flags.
    // NOTE: all state here uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count     <= '0;
            r_pop_data  <= '0;
            r_pop_valid <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            unique case (w_op)
                OP_PUSH: r_count <= r_count + CNT_W'(1);
                OP_POP:  r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            r_pop_valid <= w_pop_acc;
            if (w_pop_acc) begin
                r_pop_data <= w_top_data;
            end
            // A new error in the clearing cycle wins over the clear.
            r_overflow  <= (r_overflow  && !clr_err) || w_push_drop;
            r_underflow <= (r_underflow && !clr_err) || w_pop_reject;
        end
    end

    assign pop_data  = r_pop_data;
    assign pop_valid = r_pop_valid;
    assign top_data  = w_top_data;
    assign empty     = w_empty;
    assign full      = w_full;
    assign count     = r_count;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;

`ifdef LIFO_WATERMARK_EN
    assign almost_full  = (r_count >= CNT_W'(AFULL_LVL));
    assign almost_empty = (r_count <= CNT_W'(1));
`else
    // Watermark outputs are not built in this configuration.
`endif

endmodule : lifo_stack

// File: tb/tb_lifo_stack.sv
// Self-checking bench for lifo_stack (DATA_W=8, DEPTH=4). A queue-based
// reference model tracks the stack; directed sequences cover the boundary
// cases, then randomized push/pop/clear/reset traffic follows.
// Build with LIFO_WATERMARK_EN defined to also check the watermark outputs.
module tb_lifo_stack;

    localparam int DATA_W    = 8;
    localparam int DEPTH     = 4;
    localparam int AFULL_LVL = 3;
    localparam int CNT_W     = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic              push;
    logic [DATA_W-1:0] push_data;
    logic              pop;
    logic              clr_err;
    logic [DATA_W-1:0] pop_data;
    logic              pop_valid;
    logic [DATA_W-1:0] top_data;
    logic              empty;
    logic              full;
    logic [CNT_W-1:0]  count;
    logic              overflow;
    logic              underflow;
`ifdef LIFO_WATERMARK_EN
    logic              almost_full;
    logic              almost_empty;
`endif

    always #5 clk = ~clk;

    lifo_stack #(
        .DATA_W    (DATA_W),
        .DEPTH     (DEPTH),
        .AFULL_LVL (AFULL_LVL)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .push         (push),
        .push_data    (push_data),
        .pop          (pop),
        .clr_err      (clr_err),
        .pop_data     (pop_data),
        .pop_valid    (pop_valid),
        .top_data     (top_data),
        .empty        (empty),
        .full         (full),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
`ifdef LIFO_WATERMARK_EN
        ,
        .almost_full  (almost_full),
        .almost_empty (almost_empty)
`endif
    );

    int n_cmp = 0;
    int n_mis = 0;

    // Reference model state.
    logic [DATA_W-1:0] m_q[$];
    logic [DATA_W-1:0] m_pd;
    logic              m_pv;
    logic              m_ovf;
    logic              m_udf;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_pd  = '0;
        m_pv  = 1'b0;
        m_ovf = 1'b0;
        m_udf = 1'b0;
    endtask

    // Apply one edge's worth of requests to the model.
    task automatic model_step(input logic p, input logic [DATA_W-1:0] d,
                              input logic o, input logic c);
        logic oerr;
        logic uerr;
        oerr = 1'b0;
        uerr = 1'b0;
        m_pv = 1'b0;
        if (p && o && (m_q.size() > 0)) begin
            m_pd = m_q[$];
            m_q[$] = d;
            m_pv = 1'b1;
        end else if (p) begin
            if (m_q.size() < DEPTH) m_q.push_back(d);
            else oerr = 1'b1;
            if (o) uerr = 1'b1;
        end else if (o) begin
            if (m_q.size() > 0) begin
                m_pd = m_q.pop_back();
                m_pv = 1'b1;
            end else begin
                uerr = 1'b1;
            end
        end
        m_ovf = (m_ovf && !c) || oerr;
        m_udf = (m_udf && !c) || uerr;
    endtask

    task automatic check_state(input string ctx);
        check({ctx, ".count"},     32'(count),     32'(m_q.size()));
        check({ctx, ".empty"},     32'(empty),     32'(m_q.size() == 0));
        check({ctx, ".full"},      32'(full),      32'(m_q.size() == DEPTH));
        check({ctx, ".pop_valid"}, 32'(pop_valid), 32'(m_pv));
        check({ctx, ".pop_data"},  32'(pop_data),  32'(m_pd));
        check({ctx, ".overflow"},  32'(overflow),  32'(m_ovf));
        check({ctx, ".underflow"}, 32'(underflow), 32'(m_udf));
        if (m_q.size() > 0) begin
            check({ctx, ".top_data"}, 32'(top_data), 32'(m_q[$]));
        end
`ifdef LIFO_WATERMARK_EN
        check({ctx, ".almost_full"},  32'(almost_full),  32'(m_q.size() >= AFULL_LVL));
        check({ctx, ".almost_empty"}, 32'(almost_empty), 32'(m_q.size() <= 1));
`endif
    endtask

    // Drive one cycle of requests, let the edge happen, then compare.
    task automatic step(input logic p, input logic [DATA_W-1:0] d,
                        input logic o, input logic c, input string ctx);
        push      = p;
        push_data = d;
        pop       = o;
        clr_err   = c;
        @(posedge clk);
        model_step(p, d, o, c);
        #1;
        check_state(ctx);
    endtask

    // Assert reset between edges and confirm outputs clear before the next edge.
    task automatic async_reset(input string ctx);
        push    = 1'b0;
        pop     = 1'b0;
        clr_err = 1'b0;
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check_state(ctx);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DATA_W-1:0] exp_pops [4];
        exp_pops = '{8'h44, 8'h33, 8'h22, 8'h11};

        rst       = 1'b1;
        push      = 1'b0;
        push_data = '0;
        pop       = 1'b0;
        clr_err   = 1'b0;
        model_reset();
        #12;
        check_state("in_reset");
        @(negedge clk);
        rst = 1'b0;
        step(0, 8'h00, 0, 0, "idle");
        check("idle.count_const", 32'(count), 32'd0);
        check("idle.empty_const", 32'(empty), 32'd1);

        // Fill to capacity, then overflow.
        step(1, 8'h11, 0, 0, "push1");
        step(1, 8'h22, 0, 0, "push2");
        step(1, 8'h33, 0, 0, "push3");
        step(1, 8'h44, 0, 0, "push4");
        check("fill.full_const", 32'(full), 32'd1);
        check("fill.top_const",  32'(top_data), 32'h44);
        step(1, 8'h55, 0, 0, "push_ovf");
        check("ovf.flag_const", 32'(overflow), 32'd1);
        check("ovf.top_const",  32'(top_data), 32'h44);

        // Drain in reverse order, then underflow.
        for (int i = 0; i < 4; i++) begin
            step(0, 8'h00, 1, 0, "drain");
            check("drain.pop_data_const", 32'(pop_data), 32'(exp_pops[i]));
        end
        step(0, 8'h00, 1, 0, "pop_udf");
        check("udf.pop_data_hold", 32'(pop_data), 32'h11);
        step(0, 8'h00, 0, 1, "clr1");

        // Replace-top, then replace-top at full (no overflow).
        step(1, 8'hA1, 0, 0, "pushA1");
        step(1, 8'hB2, 0, 0, "pushB2");
        step(1, 8'hC3, 1, 0, "swap");
        check("swap.pop_data_const", 32'(pop_data), 32'hB2);
        check("swap.top_const",      32'(top_data), 32'hC3);
        step(1, 8'h01, 0, 0, "push01");
        step(1, 8'h02, 0, 0, "push02");
        step(1, 8'hD4, 1, 0, "swap_full");
        check("swap_full.no_ovf", 32'(overflow), 32'd0);
        for (int i = 0; i < 4; i++) step(0, 8'h00, 1, 0, "drain2");

        // Push+pop on empty, clearing, and error-beats-clear.
        step(1, 8'h5A, 1, 0, "swap_empty");
        check("swap_empty.udf", 32'(underflow), 32'd1);
        check("swap_empty.top", 32'(top_data), 32'h5A);
        step(0, 8'h00, 0, 1, "clr2");
        step(0, 8'h00, 1, 0, "pop5A");
        step(0, 8'h00, 1, 1, "clr_vs_udf");
        check("clr_vs_udf.const", 32'(underflow), 32'd1);

        // Asynchronous reset with count=3 and a live pop_valid.
        step(0, 8'h00, 0, 1, "clr3");
        for (int i = 0; i < 4; i++) step(1, 8'(8'h60 + i), 0, 0, "refill");
        step(0, 8'h00, 1, 0, "pre_rst_pop");
        check("pre_rst.pop_valid", 32'(pop_valid), 32'd1);
        async_reset("async_rst");

        // Randomized traffic with phases biased toward filling or draining.
        for (int i = 0; i < 1500; i++) begin
            int          bias;
            logic        p;
            logic        o;
            logic        c;
            bias = ((i / 60) % 2 == 0) ? 70 : 30;
            p = ($urandom_range(0, 99) < bias);
            o = ($urandom_range(0, 99) < (100 - bias));
            c = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 299) == 0) begin
                async_reset("rand_rst");
            end else begin
                step(p, 8'($urandom), o, c, "rand");
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule : tb_lifo_stack

// File: doc/lifo_stack.md
Name: lifo_stack

Overview:
- Parametrised synchronous LIFO stack for the buffering library; next generation of the fixed 8x8 stack.
- Generalised in data width and depth; true DEPTH-entry capacity.
- Adds:
  - a registered pop-data valid strobe
  - a same-cycle push+pop (replace-top) operation
  - a combinational peek of the top entry
  - an occupancy count
  - sticky overflow/underflow error flags

Parameters:
- DATA_W, 8, width of each stack entry.
- DEPTH, 8, number of entries (>=2); full asserts at count == DEPTH.
- AFULL_LVL, DEPTH-2, almost-full threshold; used only with LIFO_WATERMARK_EN.
- CNT_W (localparam), $clog2(DEPTH+1), width of count.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- push  in  1  push request.
- push_data  in  DATA_W  data to push.
- pop  in  1  pop request.
- pop_data  out  DATA_W  registered popped entry; holds its value until the next accepted pop.
- pop_valid  out  1  high for exactly one cycle after an accepted pop.
- top_data  out  DATA_W  combinational peek of mem[count-1]; don't-care when empty.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.
- count  out  CNT_W  current occupancy.
- overflow  out  1  sticky: a push was dropped.
- underflow  out  1  sticky: a pop was rejected.
- clr_err  in  1  synchronous clear of overflow/underflow.

Behaviour:
- Reset (async assert, sync-to-clk deassert assumed upstream):
  - count=0, pop_data=0, pop_valid=0, overflow=0, underflow=0.
  - Storage is not reset.
  - Reset mid-operation discards all contents; an in-flight pop_valid is cleared immediately.
- Storage: mem[0..DEPTH-1]; the top is mem[count-1]. Pointer is the count itself; no wrap-around. Index arithmetic is done in CNT_W bits.
- Per-cycle decision, registered on clk:
  - push only, !full: mem[count] <= push_data; count+1.
  - push only, full: data dropped; count unchanged; overflow <= 1.
  - pop only, !empty: pop_data <= mem[count-1]; count-1; pop_valid <= 1.
  - pop only, empty: pop_data holds; pop_valid <= 0; underflow <= 1.
  - push+pop, !empty (includes full): pop_data <= mem[count-1]; mem[count-1] <= push_data; count unchanged; pop_valid <= 1. No overflow, even when full.
  - push+pop, empty: treated as push only (count 0->1); pop rejected; underflow <= 1; pop_valid <= 0.
  - neither: all state holds; pop_valid <= 0.
- Latency:
  - pop_data/pop_valid appear one cycle after the accepting edge.
  - top_data, empty, full and count reflect the post-edge state combinationally from registers.
- clr_err clears both sticky flags. If an error occurs in the same cycle as clr_err, the new error wins (flag set).
- empty/full/count are derived from the count register only; they are never registered separately.

Optional Feature:
- Macro LIFO_WATERMARK_EN.
- Defined:
  - Adds output almost_full (1 bit) = (count >= AFULL_LVL).
  - Adds output almost_empty (1 bit) = (count <= 1).
  - Both combinational from count.
- Undefined: both ports and the AFULL_LVL comparison logic are absent; all other behaviour is identical.

Decomposition:
- Shared package lifo_pkg holds:
  - the op-decode enum {OP_IDLE, OP_PUSH, OP_POP, OP_SWAP}
  - a clog2-based count-width helper constant function
- One natural sub-module: lifo_mem.
  - DATA_W x DEPTH register array.
  - One synchronous write port; one async read port addressed at count-1.
- lifo_stack holds the op decode, count, error flags and pop_data register.

Test Plan (DATA_W=8, DEPTH=4):
- Reset then idle -> count=0, empty=1, full=0, pop_valid=0, pop_data=0x00, flags=0.
- Push 0x11,0x22,0x33,0x44 -> full=1, count=4, top_data=0x44. Fifth push 0x55 -> count stays 4, overflow=1, top_data=0x44.
- From full, pop x4 -> pop_data 0x44,0x33,0x22,0x11, each with a one-cycle pop_valid one cycle after pop; empty=1. Fifth pop -> underflow=1, pop_valid=0, pop_data holds 0x11.
- Count=2 (0xA1,0xB2); push 0xC3 with pop -> pop_data=0xB2, pop_valid=1, count=2, top_data=0xC3. Repeat at full -> no overflow.
- Empty; push 0x5A with pop -> count=1, top_data=0x5A, underflow=1, pop_valid=0. Then clr_err -> flags 0. clr_err with a simultaneous empty pop -> underflow stays 1.
- Assert rst asynchronously between edges with count=3 and pop_valid=1 -> outputs reach reset values before the next edge. With LIFO_WATERMARK_EN, AFULL_LVL=3: almost_full toggles at count 3, almost_empty at count<=1.
